// File: rtl/capture_ctrl.sv
// ---------------------------------------------------------------------------
// capture_ctrl
//
// Purpose:
//   Sequences writes of packed sample words into the circular capture RAM.
//   A capture fills the pre-trigger region, arms, waits for a trigger while
//   continuing to overwrite the oldest data, then writes a programmable
//   number of post-trigger words and stops with a done flag.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst_n         in   asynchronous active-low reset
//   wrt_smpl      in   one-clk pulse: a sample word is ready this cycle
//   start         in   one-clk pulse: begin a new capture (IDLE or DONE only)
//   abort         in   terminate the capture immediately
//   trig_in       in   trigger event, level sampled each clk
//   trig_pos      in   words to write after the trigger (0..ENTRIES-1)
//   done_clr      in   acknowledge/clear capture_done
//   we            out  RAM write enable (combinational)
//   waddr         out  RAM write address, valid in the same cycle as we
//   armed         out  pre-trigger region full, trigger may be accepted
//   triggered     out  trigger has been accepted this capture
//   capture_done  out  capture complete
//   trace_end     out  address of the last word written in this capture
//   state_dbg     out  current FSM state encoding, for observation only
//
// Handshake: there is no back-pressure. wrt_smpl is a qualifier pulse; the
// write happens in the cycle we is high and the RAM must accept it then.
//
// ENTRIES must equal 2**ADDR_W; address wrap relies on natural overflow.
// ---------------------------------------------------------------------------
module capture_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int ENTRIES = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic              start,
    input  logic              abort,
    input  logic              trig_in,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              done_clr,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ARM  = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    // ENTRIES needs one extra bit so that trig_pos == 0 gives a full-depth
    // pre-trigger region.
    localparam logic [ADDR_W:0] ENTRIES_W = (ADDR_W+1)'(ENTRIES);

    state_t              state_q,        state_d;
    logic [ADDR_W-1:0]   waddr_q,        waddr_d;
    logic [ADDR_W:0]     pre_cnt_q,      pre_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q,     post_cnt_d;
    logic                armed_q,        armed_d;
    logic                triggered_q,    triggered_d;
    logic                capture_done_q, capture_done_d;
    logic [ADDR_W-1:0]   trace_end_q,    trace_end_d;

    logic                writing_state;
    logic [ADDR_W-1:0]   waddr_inc;
    logic [ADDR_W:0]     pre_cnt_inc;
    logic [ADDR_W-1:0]   post_cnt_inc;
    logic [ADDR_W:0]     arm_target;
    logic [ADDR_W-1:0]   last_addr;

    assign writing_state = (state_q == PRE) || (state_q == ARM) || (state_q == POST);
    assign we            = wrt_smpl & writing_state & ~abort;

    assign waddr_inc    = waddr_q + ADDR_W'(1);
    assign pre_cnt_inc  = pre_cnt_q + (ADDR_W+1)'(1);
    assign post_cnt_inc = post_cnt_q + ADDR_W'(1);
    assign arm_target   = ENTRIES_W - {1'b0, trig_pos};

    // When the trigger lands with no write in the same cycle, the last word
    // written sits one address behind the current write pointer.
    assign last_addr = we ? waddr_q : (waddr_q - ADDR_W'(1));

    always_comb begin
        state_d        = state_q;
        waddr_d        = waddr_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        armed_d        = armed_q;
        triggered_d    = triggered_q;
        capture_done_d = capture_done_q;
        trace_end_d    = trace_end_q;

        if (abort) begin
            // trace_end survives an abort so the previous capture can still
            // be located in the RAM.
            state_d        = IDLE;
            waddr_d        = '0;
            pre_cnt_d      = '0;
            post_cnt_d     = '0;
            armed_d        = 1'b0;
            triggered_d    = 1'b0;
            capture_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d        = PRE;
                        waddr_d        = '0;
                        pre_cnt_d      = '0;
                        post_cnt_d     = '0;
                        armed_d        = 1'b0;
                        triggered_d    = 1'b0;
                        capture_done_d = 1'b0;
                    end
                end

                PRE: begin
                    // trig_in is deliberately ignored until the pre-trigger
                    // region is full.
                    if (we) begin
                        waddr_d   = waddr_inc;
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == arm_target) begin
                            state_d = ARM;
                            armed_d = 1'b1;
                        end
                    end
                end

                ARM: begin
                    // A write coinciding with the trigger belongs to the
                    // pre-trigger data and is not counted in post_cnt.
                    if (we) begin
                        waddr_d = waddr_inc;
                    end
                    if (trig_in) begin
                        triggered_d = 1'b1;
                        if (trig_pos == '0) begin
                            state_d        = DONE;
                            capture_done_d = 1'b1;
                            trace_end_d    = last_addr;
                        end else begin
                            state_d = POST;
                        end
                    end
                end

                POST: begin
                    if (we) begin
                        waddr_d    = waddr_inc;
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == trig_pos) begin
                            state_d        = DONE;
                            capture_done_d = 1'b1;
                            trace_end_d    = waddr_q;
                        end
                    end
                end

                DONE: begin
                    // start wins over done_clr so a host can re-launch and
                    // acknowledge in one cycle.
                    if (start) begin
                        state_d        = PRE;
                        waddr_d        = '0;
                        pre_cnt_d      = '0;
                        post_cnt_d     = '0;
                        armed_d        = 1'b0;
                        triggered_d    = 1'b0;
                        capture_done_d = 1'b0;
                    end else if (done_clr) begin
                        state_d        = IDLE;
                        armed_d        = 1'b0;
                        triggered_d    = 1'b0;
                        capture_done_d = 1'b0;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            waddr_q        <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            armed_q        <= 1'b0;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            trace_end_q    <= '0;
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            armed_q        <= armed_d;
            triggered_q    <= triggered_d;
            capture_done_q <= capture_done_d;
            trace_end_q    <= trace_end_d;
        end
    end

    assign waddr        = waddr_q;
    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign capture_done = capture_done_q;
    assign trace_end    = trace_end_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl
//
// Directed bench for capture_ctrl at ADDR_W=4 / ENTRIES=16. Every expected
// RAM write address is queued when the sample pulse is driven; a monitor
// pops and compares on each observed write. Registered outputs are checked
// 1 time unit after the active clock edge.
// ---------------------------------------------------------------------------
module tb_capture_ctrl;

    localparam int AW  = 4;
    localparam int ENT = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          wrt_smpl;
    logic          start;
    logic          abort;
    logic          trig_in;
    logic [AW-1:0] trig_pos;
    logic          done_clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          triggered;
    logic          capture_done;
    logic [AW-1:0] trace_end;
    logic [2:0]    state_dbg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    capture_ctrl #(
        .ADDR_W  (AW),
        .ENTRIES (ENT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrt_smpl     (wrt_smpl),
        .start        (start),
        .abort        (abort),
        .trig_in      (trig_in),
        .trig_pos     (trig_pos),
        .done_clr     (done_clr),
        .we           (we),
        .waddr        (waddr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .trace_end    (trace_end),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;
    int            vectors;
    int            miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every write seen on the RAM port must match the next queued address.
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {31'd0, we}, 32'd0);
            end else begin
                chk("waddr", {28'd0, waddr}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic w, input logic s, input logic t,
                        input logic a, input logic dc, input logic exp_wr);
        wrt_smpl = w;
        start    = s;
        trig_in  = t;
        abort    = a;
        done_clr = dc;
        if (exp_wr) begin
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 4'd1;
        end
        @(posedge clk);
        #1;
        wrt_smpl = 1'b0;
        start    = 1'b0;
        trig_in  = 1'b0;
        abort    = 1'b0;
        done_clr = 1'b0;
    endtask

    task automatic wr(input int n, input logic exp_wr);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_wr);
    endtask

    task automatic start_cap(input logic dc);
        exp_addr = '0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, dc, 1'b0);  // sample pulse in start cycle must not write
    endtask

    task automatic trig();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_addr    = '0;
        rst_n       = 1'b0;
        wrt_smpl    = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        trig_in     = 1'b0;
        trig_pos    = '0;
        done_clr    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        chk("rst_waddr", {28'd0, waddr}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_trig", {31'd0, triggered}, 32'd0);
        chk("rst_done", {31'd0, capture_done}, 32'd0);
        chk("rst_trace_end", {28'd0, trace_end}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: trig_pos=4, 14 pre writes, trigger, 4 post writes
        trig_pos = 4'd4;
        start_cap(1'b0);
        chk("t1_state_pre", {29'd0, state_dbg}, {29'd0, S_PRE});
        chk("t1_waddr0", {28'd0, waddr}, 32'd0);
        wr(11, 1'b1);
        chk("t1_armed_early", {31'd0, armed}, 32'd0);
        wr(1, 1'b1);
        chk("t1_armed", {31'd0, armed}, 32'd1);
        chk("t1_state_arm", {29'd0, state_dbg}, {29'd0, S_ARM});
        wr(2, 1'b1);
        chk("t1_waddr14", {28'd0, waddr}, 32'd14);
        trig();
        chk("t1_triggered", {31'd0, triggered}, 32'd1);
        chk("t1_state_post", {29'd0, state_dbg}, {29'd0, S_POST});
        wr(3, 1'b1);
        chk("t1_done_early", {31'd0, capture_done}, 32'd0);
        wr(1, 1'b1);
        chk("t1_done", {31'd0, capture_done}, 32'd1);
        chk("t1_trace_end", {28'd0, trace_end}, 32'd1);
        chk("t1_state_done", {29'd0, state_dbg}, {29'd0, S_DONE});
        wr(2, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_clr_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        chk("t1_clr_done", {31'd0, capture_done}, 32'd0);
        chk("t1_clr_armed", {31'd0, armed}, 32'd0);
        chk("t1_clr_trig", {31'd0, triggered}, 32'd0);
        chk("t1_keep_trace_end", {28'd0, trace_end}, 32'd1);

        // T2: trigger in PRE ignored, start in PRE ignored, later trigger accepted
        start_cap(1'b0);
        wr(5, 1'b1);
        trig();
        chk("t2_pre_trig_ignored", {31'd0, triggered}, 32'd0);
        chk("t2_still_pre", {29'd0, state_dbg}, {29'd0, S_PRE});
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_start_ignored", {28'd0, waddr}, 32'd6);
        wr(6, 1'b1);
        chk("t2_armed", {31'd0, armed}, 32'd1);
        wr(3, 1'b1);
        trig();
        chk("t2_state_post", {29'd0, state_dbg}, {29'd0, S_POST});
        wr(4, 1'b1);
        chk("t2_done", {31'd0, capture_done}, 32'd1);
        chk("t2_trace_end", {28'd0, trace_end}, 32'd2);

        // T3: start with done_clr in DONE, trig_pos=0 full-depth pre region
        trig_pos = 4'd0;
        start_cap(1'b1);
        chk("t3_state_pre", {29'd0, state_dbg}, {29'd0, S_PRE});
        chk("t3_done_cleared", {31'd0, capture_done}, 32'd0);
        chk("t3_waddr0", {28'd0, waddr}, 32'd0);
        chk("t3_armed_cleared", {31'd0, armed}, 32'd0);
        wr(15, 1'b1);
        chk("t3_not_armed", {29'd0, state_dbg}, {29'd0, S_PRE});
        wr(1, 1'b1);
        chk("t3_state_arm", {29'd0, state_dbg}, {29'd0, S_ARM});
        chk("t3_waddr_wrapped", {28'd0, waddr}, 32'd0);
        trig();
        chk("t3_state_done", {29'd0, state_dbg}, {29'd0, S_DONE});
        chk("t3_done", {31'd0, capture_done}, 32'd1);
        chk("t3_trace_end", {28'd0, trace_end}, 32'd15);
        chk("t3_triggered", {31'd0, triggered}, 32'd1);

        // T5: abort during POST at waddr=7
        trig_pos = 4'd9;
        start_cap(1'b0);
        wr(7, 1'b1);
        chk("t5_state_arm", {29'd0, state_dbg}, {29'd0, S_ARM});
        trig();
        chk("t5_waddr7", {28'd0, waddr}, 32'd7);
        chk("t5_state_post", {29'd0, state_dbg}, {29'd0, S_POST});
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_state_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
        chk("t5_armed", {31'd0, armed}, 32'd0);
        chk("t5_trig", {31'd0, triggered}, 32'd0);
        chk("t5_done", {31'd0, capture_done}, 32'd0);
        chk("t5_waddr", {28'd0, waddr}, 32'd0);
        chk("t5_keep_trace_end", {28'd0, trace_end}, 32'd15);

        // T6: asynchronous reset while armed
        trig_pos = 4'd4;
        start_cap(1'b0);
        wr(12, 1'b1);
        chk("t6_state_arm", {29'd0, state_dbg}, {29'd0, S_ARM});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        chk("t6_armed", {31'd0, armed}, 32'd0);
        chk("t6_waddr", {28'd0, waddr}, 32'd0);
        chk("t6_trace_end", {28'd0, trace_end}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T4: trigger and write in the same ARM cycle, trig_pos=2
        trig_pos = 4'd2;
        start_cap(1'b0);
        wr(14, 1'b1);
        chk("t4_state_arm", {29'd0, state_dbg}, {29'd0, S_ARM});
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_state_post", {29'd0, state_dbg}, {29'd0, S_POST});
        chk("t4_waddr15", {28'd0, waddr}, 32'd15);
        wr(1, 1'b1);
        chk("t4_done_early", {31'd0, capture_done}, 32'd0);
        wr(1, 1'b1);
        chk("t4_done", {31'd0, capture_done}, 32'd1);
        chk("t4_trace_end", {28'd0, trace_end}, 32'd0);
        wr(1, 1'b0);

        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
